// File: rtl/iob_fifo_sync_asym_pkg.sv
// Shared width helpers for the asymmetric FIFO and its RAM wrapper.
package iob_fifo_sync_asym_pkg;

  function automatic int IOB_MAX(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int IOB_MIN(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int iob_asym_ratio(input int w_w, input int r_w);
    return IOB_MAX(w_w, r_w) / IOB_MIN(w_w, r_w);
  endfunction

  function automatic int iob_asym_r_addr_w(
    input int addr_w,
    input int w_w,
    input int r_w
  );
    return addr_w - $clog2(iob_asym_ratio(w_w, r_w));
  endfunction

endpackage

// File: rtl/iob_fifo_asym_level.sv
// Occupancy counter in write words, with registered full/empty flags.
module iob_fifo_asym_level #(
  parameter int ADDR_W = 4,
  parameter int R      = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            wa_i,
  input  logic            ra_i,
  output logic [ADDR_W:0] level_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] R_L   = LW'(R);
  localparam logic [LW-1:0] DEPTH = LW'(1) << ADDR_W;

  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  always_comb begin
    level_d = level_q
            + {{(LW-1){1'b0}}, wa_i}
            - (ra_i ? R_L : '0);
    full_d  = (level_d == DEPTH);
    empty_d = (level_d < R_L);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/iob_fifo_sync_asym.sv
// Synchronous FIFO controller, narrow write / wide read, for an
// asymmetric two-port RAM whose first-written word sits in the LSBs.
module iob_fifo_sync_asym
  import iob_fifo_sync_asym_pkg::*;
#(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 4,
  parameter int R        = iob_asym_ratio(W_DATA_W, R_DATA_W),
  parameter int R_ADDR_W = iob_asym_r_addr_w(ADDR_W, W_DATA_W, R_DATA_W)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                w_en_i,
  input  logic [W_DATA_W-1:0] w_data_i,
  output logic                w_full_o,
  output logic                w_ovf_o,
  input  logic                r_en_i,
  output logic [R_DATA_W-1:0] r_data_o,
  output logic                r_valid_o,
  output logic                r_empty_o,
  output logic                r_unf_o,
  output logic [ADDR_W:0]     level_o,
  output logic                ext_mem_w_en_o,
  output logic [ADDR_W-1:0]   ext_mem_w_addr_o,
  output logic [W_DATA_W-1:0] ext_mem_w_data_o,
  output logic                ext_mem_r_en_o,
  output logic [R_ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [R_DATA_W-1:0] ext_mem_r_data_i
);

  logic                wa, ra;
  logic                full, empty;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [R_ADDR_W-1:0] rptr_q, rptr_d;
  logic                r_valid_q, ovf_q, unf_q;

  assign wa = w_en_i & ~full;
  assign ra = r_en_i & ~empty;

  iob_fifo_asym_level #(
    .ADDR_W (ADDR_W),
    .R      (R)
  ) u_level (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wa_i    (wa),
    .ra_i    (ra),
    .level_o (level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    wptr_d = wa ? wptr_q + 1'b1 : wptr_q;
    rptr_d = ra ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      r_valid_q <= ra;
      ovf_q     <= w_en_i & full;
      unf_q     <= r_en_i & empty;
    end
  end

  assign ext_mem_w_en_o   = wa;
  assign ext_mem_w_addr_o = wptr_q;
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = ra;
  assign ext_mem_r_addr_o = rptr_q;

  // Hold zero when idle so stale RAM output never leaks downstream.
  assign r_data_o  = r_valid_q ? ext_mem_r_data_i : '0;
  assign r_valid_o = r_valid_q;
  assign w_full_o  = full;
  assign r_empty_o = empty;
  assign w_ovf_o   = ovf_q;
  assign r_unf_o   = unf_q;

endmodule
